dx_xm_pipe_regs: RTL and testbench
==================================

Name: dx_xm_pipe_regs

Overview:
- Decode->Execute (ID/EX) and Execute->Memory (EX/MEM) pipeline register chain for the rv32i core.
- Consumes stallD/flushE from hazard_unit.
- Produces the E- and M-stage destination and type fields (regwriteE, RdE, RdM) that hazard_unit compares against Rs1D/Rs2D, closing the hazard loop.
- Inserts bubbles, tracks per-stage valid bits and checks the stall/flush protocol.

Parameters:
- REG_WIDTH, 5, register index width.
- XLEN, 32, datapath width (PC, operands, immediate, ALU result).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- stallD  input  1  decode stall from hazard_unit.
- flushE  input  1  execute flush from hazard_unit.
- validD  input  1  decode slot holds a real instruction.
- instr_typeD  input  instr_type_t  decoded instruction class (rv32i_pkg).
- Rs1D  input  REG_WIDTH  source 1 index.
- Rs2D  input  REG_WIDTH  source 2 index.
- RdD  input  REG_WIDTH  destination index.
- pcD  input  XLEN  decode PC.
- rs1_dataD  input  XLEN  register-file read 1.
- rs2_dataD  input  XLEN  register-file read 2.
- immD  input  XLEN  immediate.
- alu_resultE  input  XLEN  ALU output for the E-stage instruction.
- validE  output  1  E slot valid.
- regwriteE  output  instr_type_t  E-stage instruction class.
- Rs1E  output  REG_WIDTH  E-stage source 1 index.
- Rs2E  output  REG_WIDTH  E-stage source 2 index.
- RdE  output  REG_WIDTH  E-stage destination index.
- pcE  output  XLEN  E-stage PC.
- rs1_dataE  output  XLEN  E-stage operand 1.
- rs2_dataE  output  XLEN  E-stage operand 2.
- immE  output  XLEN  E-stage immediate.
- validM  output  1  M slot valid.
- regwriteM  output  instr_type_t  M-stage instruction class.
- RdM  output  REG_WIDTH  M-stage destination index.
- alu_resultM  output  XLEN  M-stage ALU result.
- rs2_dataM  output  XLEN  M-stage store data.
- proto_err  output  1  sticky stall/flush protocol violation.
- bubble_cnt  output  32  bubbles inserted (optional feature).
- instr_cnt  output  32  valid instructions entering M (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Every E/M register holds the bubble value: valid=0, type=S_TYPE, all indices 0, all data 0.
  - proto_err=0; counters 0; FSM enters RUN.
- Bubble value: valid=0, type=S_TYPE (non-writing class), Rs1/Rs2/Rd=0, data fields 0.
- Latency: one cycle D->E and one cycle E->M. The M stage never stalls.
- E-stage load rule on each rising clk:
  - stallD=1 or flushE=1: E loads the bubble.
  - Otherwise: E loads all D fields, with validE<=validD.
  - validD=0 without stall/flush: E still loads the bubble value (type=S_TYPE, Rd=0).
- M-stage load rule on each rising clk:
  - M loads validE, regwriteE, RdE, rs2_dataE and alu_resultE.
  - When validE=0, M loads the bubble value and alu_resultM=0.
- Protocol FSM:
  - States RUN and HOLD.
  - RUN -> HOLD when stallD=1 and flushE=1 (load-use bubble inserted).
  - HOLD -> RUN when stallD=0.
  - HOLD with stallD=1 again: legal, stays in HOLD.
- Protocol violation:
  - stallD=1 with flushE=0 in any state sets proto_err on the next edge.
  - E still loads the bubble, so no instruction is duplicated.
  - proto_err is cleared only by reset.
- flushE=1 with stallD=0 (branch flush): legal; bubble in E; FSM stays in RUN.
- Reset asserted mid-stall: all state is cleared asynchronously. The first edge after release behaves as RUN with empty stages.

Optional Feature:
- Macro: DX_XM_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on every edge where E loads the bubble because of stallD or flushE.
  - instr_cnt increments on every edge where M loads validE=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with validD=1 -> validE=validM=0, regwriteE=S_TYPE, RdE=RdM=0 immediately, without waiting for a clock edge.
- Plain flow: validD=1, I_TYPE_LOAD, RdD=2, alu_resultE=32'h100, no stall -> next edge validE=1, RdE=2, regwriteE=I_TYPE_LOAD; following edge RdM=2, alu_resultM=32'h100, validM=1.
- Load-use bubble:
  - Stimulus: stallD=flushE=1 for one cycle with RdD=6.
  - E: validE=0, RdE=0 for that cycle; previous E contents move to M.
  - FSM: passes RUN->HOLD->RUN.
  - bubble_cnt: +1 when DX_XM_PERF_CNT_EN is defined.
- Branch flush: flushE=1, stallD=0 -> E bubble; proto_err stays 0.
- Protocol violation: stallD=1, flushE=0 with RdD=7 -> RdE=0 (not 7); proto_err=1 and stays 1 until rst_n=0.
- Counters (DX_XM_PERF_CNT_EN defined): 10 valid instructions with 3 load-use stalls -> instr_cnt=10, bubble_cnt=3.

Source files
------------

// File: rtl/dx_xm_pipe_regs.sv
// rv32i instruction classes plus the ID/EX and EX/MEM pipeline registers with stall/flush protocol checking.
// Optional performance counters are built only when DX_XM_PERF_CNT_EN is defined.

package rv32i_pkg;
   typedef enum logic [2:0] {
      R_TYPE      = 3'd0,
      I_TYPE_ALU  = 3'd1,
      I_TYPE_LOAD = 3'd2,
      I_TYPE_JALR = 3'd3,
      S_TYPE      = 3'd4,
      B_TYPE      = 3'd5,
      U_TYPE      = 3'd6,
      J_TYPE      = 3'd7
   } instr_type_t;
endpackage

// state | meaning
// RUN   | normal flow, no load-use bubble pending
// HOLD  | load-use bubble inserted, waiting for stallD to drop
module dx_xm_pipe_regs
   import rv32i_pkg::*;
#(
   parameter int REG_WIDTH = 5,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stallD,
   input  logic                 flushE,
   input  logic                 validD,
   input  instr_type_t          instr_typeD,
   input  logic [REG_WIDTH-1:0] Rs1D,
   input  logic [REG_WIDTH-1:0] Rs2D,
   input  logic [REG_WIDTH-1:0] RdD,
   input  logic [XLEN-1:0]      pcD,
   input  logic [XLEN-1:0]      rs1_dataD,
   input  logic [XLEN-1:0]      rs2_dataD,
   input  logic [XLEN-1:0]      immD,
   input  logic [XLEN-1:0]      alu_resultE,
   output logic                 validE,
   output instr_type_t          regwriteE,
   output logic [REG_WIDTH-1:0] Rs1E,
   output logic [REG_WIDTH-1:0] Rs2E,
   output logic [REG_WIDTH-1:0] RdE,
   output logic [XLEN-1:0]      pcE,
   output logic [XLEN-1:0]      rs1_dataE,
   output logic [XLEN-1:0]      rs2_dataE,
   output logic [XLEN-1:0]      immE,
   output logic                 validM,
   output instr_type_t          regwriteM,
   output logic [REG_WIDTH-1:0] RdM,
   output logic [XLEN-1:0]      alu_resultM,
   output logic [XLEN-1:0]      rs2_dataM,
   output logic                 proto_err,
   output logic [31:0]          bubble_cnt,
   output logic [31:0]          instr_cnt
);

   typedef enum logic {RUN, HOLD} protoState_t;

   protoState_t protoState;
   logic        bubbleReq;
   logic        loadBubbleE;

   assign bubbleReq   = stallD | flushE;
   assign loadBubbleE = bubbleReq | ~validD;

   // Bubbles carry S_TYPE so hazard_unit never sees a writing class with Rd=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validE    <= 1'b0;
         regwriteE <= S_TYPE;
         Rs1E      <= '0;
         Rs2E      <= '0;
         RdE       <= '0;
         pcE       <= '0;
         rs1_dataE <= '0;
         rs2_dataE <= '0;
         immE      <= '0;
      end else if (loadBubbleE) begin
         validE    <= 1'b0;
         regwriteE <= S_TYPE;
         Rs1E      <= '0;
         Rs2E      <= '0;
         RdE       <= '0;
         pcE       <= '0;
         rs1_dataE <= '0;
         rs2_dataE <= '0;
         immE      <= '0;
      end else begin
         validE    <= 1'b1;
         regwriteE <= instr_typeD;
         Rs1E      <= Rs1D;
         Rs2E      <= Rs2D;
         RdE       <= RdD;
         pcE       <= pcD;
         rs1_dataE <= rs1_dataD;
         rs2_dataE <= rs2_dataD;
         immE      <= immD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validM      <= 1'b0;
         regwriteM   <= S_TYPE;
         RdM         <= '0;
         alu_resultM <= '0;
         rs2_dataM   <= '0;
      end else if (validE) begin
         validM      <= 1'b1;
         regwriteM   <= regwriteE;
         RdM         <= RdE;
         alu_resultM <= alu_resultE;
         rs2_dataM   <= rs2_dataE;
      end else begin
         validM      <= 1'b0;
         regwriteM   <= S_TYPE;
         RdM         <= '0;
         alu_resultM <= '0;
         rs2_dataM   <= '0;
      end
   end

   // A stall without the matching flush would replay the D instruction into E.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         protoState <= RUN;
         proto_err  <= 1'b0;
      end else begin
         if (stallD && !flushE) begin
            proto_err <= 1'b1;
         end
         case (protoState)
            RUN: begin
               if (stallD && flushE) begin
                  protoState <= HOLD;
               end
            end
            HOLD: begin
               if (!stallD) begin
                  protoState <= RUN;
               end
            end
            default: protoState <= RUN;
         endcase
      end
   end

`ifdef DX_XM_PERF_CNT_EN
   logic [31:0] bubbleCntQ;
   logic [31:0] instrCntQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubbleCntQ <= '0;
         instrCntQ  <= '0;
      end else begin
         if (bubbleReq) begin
            bubbleCntQ <= bubbleCntQ + 32'd1;
         end
         if (validE) begin
            instrCntQ <= instrCntQ + 32'd1;
         end
      end
   end

   assign bubble_cnt = bubbleCntQ;
   assign instr_cnt  = instrCntQ;
`else
   assign bubble_cnt = 32'd0;
   assign instr_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_dx_xm_pipe_regs.sv
// Directed bench for dx_xm_pipe_regs; counter expectations follow DX_XM_PERF_CNT_EN.
module tb_dx_xm_pipe_regs;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stallD, flushE, validD;
   instr_type_t instr_typeD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [31:0] pcD, rs1_dataD, rs2_dataD, immD, alu_resultE;
   logic        validE, validM, proto_err;
   instr_type_t regwriteE, regwriteM;
   logic [4:0]  Rs1E, Rs2E, RdE, RdM;
   logic [31:0] pcE, rs1_dataE, rs2_dataE, immE, alu_resultM, rs2_dataM;
   logic [31:0] bubble_cnt, instr_cnt;

   int total = 0;
   int bad = 0;

`ifdef DX_XM_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   dx_xm_pipe_regs #(.REG_WIDTH(5), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stallD(stallD), .flushE(flushE), .validD(validD),
      .instr_typeD(instr_typeD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .pcD(pcD),
      .rs1_dataD(rs1_dataD), .rs2_dataD(rs2_dataD), .immD(immD), .alu_resultE(alu_resultE),
      .validE(validE), .regwriteE(regwriteE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .pcE(pcE), .rs1_dataE(rs1_dataE), .rs2_dataE(rs2_dataE), .immE(immE),
      .validM(validM), .regwriteM(regwriteM), .RdM(RdM), .alu_resultM(alu_resultM),
      .rs2_dataM(rs2_dataM), .proto_err(proto_err), .bubble_cnt(bubble_cnt), .instr_cnt(instr_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic v, input instr_type_t t, input logic [4:0] rd, input logic [31:0] base);
      validD      = v;
      instr_typeD = t;
      RdD         = rd;
      Rs1D        = rd + 5'd1;
      Rs2D        = rd + 5'd2;
      pcD         = base;
      rs1_dataD   = base + 32'd1;
      rs2_dataD   = base + 32'd2;
      immD        = base + 32'd3;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stallD = 1'b0; flushE = 1'b0; alu_resultE = 32'd0;
      setD(1'b1, R_TYPE, 5'd0, 32'd0);
      #12;
      chk("rst_validE", 32'(validE), 32'd0);
      chk("rst_validM", 32'(validM), 32'd0);
      chk("rst_typeE", 32'(regwriteE), 32'(S_TYPE));
      chk("rst_RdE", 32'(RdE), 32'd0);
      chk("rst_RdM", 32'(RdM), 32'd0);
      chk("rst_err", 32'(proto_err), 32'd0);
      chk("rst_bcnt", bubble_cnt, 32'd0);
      chk("rst_icnt", instr_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // plain flow
      setD(1'b1, I_TYPE_LOAD, 5'd2, 32'h40);
      cycle();
      chk("flow_validE", 32'(validE), 32'd1);
      chk("flow_RdE", 32'(RdE), 32'd2);
      chk("flow_typeE", 32'(regwriteE), 32'(I_TYPE_LOAD));
      chk("flow_Rs1E", 32'(Rs1E), 32'd3);
      chk("flow_Rs2E", 32'(Rs2E), 32'd4);
      chk("flow_pcE", pcE, 32'h40);
      chk("flow_rs1E", rs1_dataE, 32'h41);
      chk("flow_rs2E", rs2_dataE, 32'h42);
      chk("flow_immE", immE, 32'h43);
      chk("flow_validM0", 32'(validM), 32'd0);
      setD(1'b0, R_TYPE, 5'd9, 32'h77);
      alu_resultE = 32'h100;
      cycle();
      chk("flow_validM", 32'(validM), 32'd1);
      chk("flow_RdM", 32'(RdM), 32'd2);
      chk("flow_aluM", alu_resultM, 32'h100);
      chk("flow_rs2M", rs2_dataM, 32'h42);
      chk("flow_typeM", 32'(regwriteM), 32'(I_TYPE_LOAD));
      chk("nv_validE", 32'(validE), 32'd0);
      chk("nv_RdE", 32'(RdE), 32'd0);
      chk("nv_typeE", 32'(regwriteE), 32'(S_TYPE));
      chk("nv_pcE", pcE, 32'd0);
      chk("nv_bcnt", bubble_cnt, 32'd0);

      // load-use bubble
      setD(1'b1, R_TYPE, 5'd5, 32'h200);
      alu_resultE = 32'hDEAD;
      cycle();
      chk("bub_aluM0", alu_resultM, 32'd0);
      chk("bub_validM0", 32'(validM), 32'd0);
      setD(1'b1, R_TYPE, 5'd6, 32'h300);
      stallD = 1'b1; flushE = 1'b1; alu_resultE = 32'h55;
      cycle();
      chk("lu_validE", 32'(validE), 32'd0);
      chk("lu_RdE", 32'(RdE), 32'd0);
      chk("lu_RdM", 32'(RdM), 32'd5);
      chk("lu_aluM", alu_resultM, 32'h55);
      chk("lu_validM", 32'(validM), 32'd1);
      chk("lu_err", 32'(proto_err), 32'd0);
      chk("lu_bcnt", bubble_cnt, PERF ? 32'd1 : 32'd0);
      stallD = 1'b0; flushE = 1'b0; alu_resultE = 32'hAA;
      cycle();
      chk("lu2_validE", 32'(validE), 32'd1);
      chk("lu2_RdE", 32'(RdE), 32'd6);
      chk("lu2_pcE", pcE, 32'h300);
      chk("lu2_validM", 32'(validM), 32'd0);
      chk("lu2_RdM", 32'(RdM), 32'd0);
      chk("lu2_aluM", alu_resultM, 32'd0);
      chk("lu2_typeM", 32'(regwriteM), 32'(S_TYPE));

      // branch flush
      setD(1'b1, I_TYPE_ALU, 5'd9, 32'h400);
      flushE = 1'b1; alu_resultE = 32'h66;
      cycle();
      chk("br_validE", 32'(validE), 32'd0);
      chk("br_RdE", 32'(RdE), 32'd0);
      chk("br_RdM", 32'(RdM), 32'd6);
      chk("br_aluM", alu_resultM, 32'h66);
      chk("br_err", 32'(proto_err), 32'd0);
      chk("br_bcnt", bubble_cnt, PERF ? 32'd2 : 32'd0);
      flushE = 1'b0;

      // protocol violation
      setD(1'b1, I_TYPE_ALU, 5'd7, 32'h500);
      stallD = 1'b1;
      cycle();
      chk("pv_RdE", 32'(RdE), 32'd0);
      chk("pv_validE", 32'(validE), 32'd0);
      chk("pv_err", 32'(proto_err), 32'd1);
      stallD = 1'b0;
      cycle();
      chk("pv2_RdE", 32'(RdE), 32'd7);
      chk("pv2_err", 32'(proto_err), 32'd1);
      cycle();
      chk("pv3_err", 32'(proto_err), 32'd1);
      chk("pv3_validM", 32'(validM), 32'd1);

      // asynchronous reset mid-cycle
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_validE", 32'(validE), 32'd0);
      chk("ar_validM", 32'(validM), 32'd0);
      chk("ar_typeE", 32'(regwriteE), 32'(S_TYPE));
      chk("ar_RdE", 32'(RdE), 32'd0);
      chk("ar_RdM", 32'(RdM), 32'd0);
      chk("ar_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 10 instructions with 3 load-use stalls
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 5 || i == 8) begin
            setD(1'b1, R_TYPE, 5'(i + 1), 32'(i * 16));
            stallD = 1'b1; flushE = 1'b1;
            cycle();
            stallD = 1'b0; flushE = 1'b0;
         end
         setD(1'b1, R_TYPE, 5'(i + 1), 32'(i * 16));
         cycle();
         if (i == 0) begin
            chk("cnt_firstRdE", 32'(RdE), 32'd1);
         end
      end
      setD(1'b0, R_TYPE, 5'd0, 32'd0);
      cycle();
      chk("cnt_lastRdM", 32'(RdM), 32'd10);
      cycle();
      chk("cnt_validM", 32'(validM), 32'd0);
      chk("cnt_err", 32'(proto_err), 32'd0);
      chk("cnt_icnt", instr_cnt, PERF ? 32'd10 : 32'd0);
      chk("cnt_bcnt", bubble_cnt, PERF ? 32'd3 : 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
